digit_entry_buffer: RTL and testbench
=====================================

# digit_entry_buffer

Parametrised keypad digit-entry buffer for the calculator front end, successor to the fixed 4-digit shift buffer. It edge-detects key strobes and stores up to DEPTH digits with push/backspace semantics. It drives a WIN-digit display window with leading-blank mask, and hands the completed operand to the arithmetic stage over a valid/ready handshake on submit. It sits between the keypad decoder and the operand registers / seven-segment driver.

## Interface
- DEPTH, 8, maximum number of stored digits (≥ WIN, ≥ 2)
- DIGIT_W, 4, bits per digit code
- WIN, 4, digits exposed on the display window
- MAX_DIGIT, 9, largest code accepted as a digit; larger codes are rejected
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-low
- num  in  DIGIT_W  digit code from keypad decoder, sampled on num_pressed edge
- num_pressed  in  1  level key strobe, synchronous to clk
- clear  in  1  level backspace strobe
- submit  in  1  level enter strobe
- out_ready  in  1  downstream accepts operand
- disp  out  WIN*DIGIT_W  most recent WIN digits; slot 0 (LSBs) = newest
- disp_blank  out  WIN  slot i blank when i ≥ cnt
- cnt  out  $clog2(DEPTH+1)  stored digit count
- full / empty  out  1  cnt==DEPTH / cnt==0
- err  out  1  one-cycle pulse on rejected event
- out_valid  out  1  operand available
- out_data  out  DEPTH*DIGIT_W  frozen buffer, slot 0 = least significant digit
- out_len  out  $clog2(DEPTH+1)  digit count of out_data

## Operation
- Each strobe passes through a rising-edge detector: event = level & ~prev. prev registers reset to 1, so a key held through reset never fires.
- States: IDLE (editing) and HOLD (operand offered).
- IDLE, priority submit > clear > num_pressed; at most one action per cycle, lower-priority simultaneous edges are dropped with no err.
- Push (num_pressed edge): if num ≤ MAX_DIGIT and not full, slots shift up one, num enters slot 0, cnt+1. If full or num > MAX_DIGIT: buffer unchanged, err pulse.
- Backspace (clear edge): if not empty, slots shift down one, top slot zero-filled, cnt−1. If empty: unchanged, err pulse.
- Submit edge: if empty, err pulse and stay IDLE. Otherwise capture buffer into out_data and cnt into out_len, assert out_valid, go to HOLD.
- HOLD: out_valid high, out_data/out_len stable. All key edges are ignored and pulse err. On out_valid & out_ready: buffer zeroed, cnt=0, out_valid low, return to IDLE.
- out_ready in IDLE has no effect.
- Unused slots (index ≥ cnt) always hold 0. disp is slots 0..WIN−1. disp_blank[i] = (i ≥ cnt).
- Reset values (reset low at a clock edge, any state including HOLD mid-handshake):
  - all slots, cnt, out_data, out_len: 0
  - out_valid, err: 0
  - empty: 1, full: 0
  - disp_blank: all 1
  - state: IDLE

## Timing
- Strobe rising at edge k is detected in cycle k. Buffer, cnt, flags and disp update at edge k+1. Latency is 1 cycle from strobe to display.
- A level held high produces exactly one event. Re-press needs at least one low cycle.
- out_valid rises the cycle after the submit edge. Transfer completes on the first edge with out_valid & out_ready. out_valid is low and cnt=0 from the following cycle.
- err is a single-cycle pulse, registered, aligned with the cycle the buffer would have updated.

## Structure
- Shared package calc_pkg holds the DIGIT_W and MAX_DIGIT defaults, the state enum (IDLE, HOLD), and the blank-digit constant used by the segment driver.
- Sub-module key_edge_detect (prev register reset to 1, event output), instantiated three times.
- Buffer is a DEPTH-slot shift register with a count register and a two-state controller. No memory macro.

## Test plan
- Reset, then press 1,2,3 → disp slot0..3 = 3,2,1,0, cnt=3, disp_blank=4'b1000, empty=0.
- Press 9 digits with DEPTH=8 → 9th rejected: cnt stays 8, full=1, err one pulse, buffer unchanged. Press code 12 on a non-full buffer → err, no change.
- Enter 4,5, clear twice, clear again → cnt 1 then 0. Third clear pulses err. Slots all 0.
- Enter 7,8, submit with out_ready=0 for 3 cycles → out_valid high, out_data slot0=8 slot1=7, out_len=2. A press in HOLD pulses err. Raise out_ready → one transfer, next cycle out_valid=0, cnt=0.
- num_pressed and clear rise the same cycle with cnt=2 → only backspace applied, cnt=1. Hold num_pressed 10 cycles → exactly one push.
- Assert reset during HOLD while holding num_pressed → all outputs at reset values. No push on release until the strobe drops and rises again.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator front-end types and constants: digit defaults, controller states, blank code.
// Pure declarations; no timing or flow control of its own.
package calc_pkg;
  localparam int DEF_DIGIT_W   = 4;
  localparam int DEF_MAX_DIGIT = 9;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Code the seven-segment driver renders as an unlit digit.
  localparam logic [DEF_DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a level key strobe; event is combinational in the first high cycle.
// prev resets to 1, so a key held through reset stays silent until released and pressed again.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic evt
);
  logic prev_q, prev_d;

  always_comb begin
    prev_d = level;
    evt    = level & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end
endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit buffer with push/backspace, display window and valid/ready operand hand-off.
// 1-cycle strobe-to-display latency; while an operand is held for out_ready, key events are refused with err.
module digit_entry_buffer
  import calc_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter int WIN       = 4,
  parameter int MAX_DIGIT = DEF_MAX_DIGIT,
  localparam int CW       = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIGIT_W-1:0]       num,
  input  logic                     num_pressed,
  input  logic                     clear,
  input  logic                     submit,
  input  logic                     out_ready,
  output logic [WIN*DIGIT_W-1:0]   disp,
  output logic [WIN-1:0]           disp_blank,
  output logic [CW-1:0]            cnt,
  output logic                     full,
  output logic                     empty,
  output logic                     err,
  output logic                     out_valid,
  output logic [DEPTH*DIGIT_W-1:0] out_data,
  output logic [CW-1:0]            out_len
);
  localparam logic [DIGIT_W-1:0] MAX_CODE = DIGIT_W'(MAX_DIGIT);

  logic num_evt, clear_evt, submit_evt;

  key_edge_detect u_num_edge    (.clk(clk), .reset(reset), .level(num_pressed), .evt(num_evt));
  key_edge_detect u_clear_edge  (.clk(clk), .reset(reset), .level(clear),       .evt(clear_evt));
  key_edge_detect u_submit_edge (.clk(clk), .reset(reset), .level(submit),      .evt(submit_evt));

  state_e                          state_q, state_d;
  logic [DEPTH-1:0][DIGIT_W-1:0]   buf_q, buf_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic [DEPTH*DIGIT_W-1:0]        out_data_q, out_data_d;
  logic [CW-1:0]                   out_len_q, out_len_d;
  logic                            is_full, is_empty;

  always_comb begin
    is_full  = (cnt_q == CW'(DEPTH));
    is_empty = (cnt_q == '0);

    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    out_data_d = out_data_q;
    out_len_d  = out_len_q;

    unique case (state_q)
      IDLE: begin
        // One action per cycle; lower-priority edges in the same cycle are dropped silently.
        if (submit_evt) begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            out_data_d = buf_q;
            out_len_d  = cnt_q;
            state_d    = HOLD;
          end
        end else if (clear_evt) begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            buf_d = {DIGIT_W'(0), buf_q[DEPTH-1:1]};
            cnt_d = cnt_q - CW'(1);
          end
        end else if (num_evt) begin
          if (is_full || (num > MAX_CODE)) begin
            err_d = 1'b1;
          end else begin
            buf_d = {buf_q[DEPTH-2:0], num};
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (submit_evt || clear_evt || num_evt) err_d = 1'b1;
        if (out_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      out_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
      out_len_q  <= out_len_d;
    end
  end

  always_comb begin
    disp = buf_q[WIN-1:0];
    for (int i = 0; i < WIN; i++) disp_blank[i] = (CW'(i) >= cnt_q);
  end

  assign cnt       = cnt_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign err       = err_q;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
endmodule

// File: tb/tb_digit_entry_buffer.sv
// Directed-vector bench for digit_entry_buffer: push, reject, backspace, hand-off, priority, reset.
module tb_digit_entry_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  num;
  logic        num_pressed, clear, submit, out_ready;
  logic [15:0] disp;
  logic [3:0]  disp_blank;
  logic [3:0]  cnt;
  logic        full, empty, err, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_len;

  int n_cmp  = 0;
  int n_fail = 0;

  digit_entry_buffer #(.DEPTH(8), .DIGIT_W(4), .WIN(4), .MAX_DIGIT(9)) dut (
    .clk(clk), .reset(reset), .num(num), .num_pressed(num_pressed), .clear(clear),
    .submit(submit), .out_ready(out_ready), .disp(disp), .disp_blank(disp_blank),
    .cnt(cnt), .full(full), .empty(empty), .err(err), .out_valid(out_valid),
    .out_data(out_data), .out_len(out_len)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; num = '0; num_pressed = 0; clear = 0; submit = 0; out_ready = 0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic press(input logic [3:0] d, output int errs);
    num = d; num_pressed = 1'b1;
    step();
    errs = int'(err);
    num_pressed = 1'b0;
    step();
    errs += int'(err);
  endtask

  task automatic backspace(output int errs);
    clear = 1'b1;
    step();
    errs = int'(err);
    clear = 1'b0;
    step();
    errs += int'(err);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cnt !== 4'd0)        begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    n_cmp++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (disp_blank !== 4'hF) begin n_fail++; $display("FAIL reset_blank got %b want 1111", disp_blank); end
    n_cmp++; if (disp !== 16'h0000)   begin n_fail++; $display("FAIL reset_disp got %h want 0000", disp); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_push();
    int e;
    do_reset();
    press(4'd1, e); press(4'd2, e); press(4'd3, e);
    n_cmp++; if (disp !== 16'h0123)   begin n_fail++; $display("FAIL push_disp got %h want 0123", disp); end
    n_cmp++; if (cnt !== 4'd3)        begin n_fail++; $display("FAIL push_cnt got %0d want 3", cnt); end
    n_cmp++; if (disp_blank !== 4'b1000) begin n_fail++; $display("FAIL push_blank got %b want 1000", disp_blank); end
    n_cmp++; if (empty !== 1'b0)      begin n_fail++; $display("FAIL push_empty got %b want 0", empty); end
  endtask

  task automatic test_full_and_reject();
    int e;
    int tot;
    do_reset();
    tot = 0;
    for (int d = 1; d <= 8; d++) begin
      press(4'(d), e);
      tot += e;
    end
    n_cmp++; if (tot !== 0)           begin n_fail++; $display("FAIL fill_err got %0d want 0", tot); end
    n_cmp++; if (full !== 1'b1)       begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    press(4'd9, e);
    n_cmp++; if (e !== 1)             begin n_fail++; $display("FAIL overflow_err_pulses got %0d want 1", e); end
    n_cmp++; if (cnt !== 4'd8)        begin n_fail++; $display("FAIL overflow_cnt got %0d want 8", cnt); end
    n_cmp++; if (disp !== 16'h5678)   begin n_fail++; $display("FAIL overflow_disp got %h want 5678", disp); end
    backspace(e);
    n_cmp++; if (disp !== 16'h4567)   begin n_fail++; $display("FAIL bs_from_full_disp got %h want 4567", disp); end
    press(4'd12, e);
    n_cmp++; if (e !== 1)             begin n_fail++; $display("FAIL badcode_err got %0d want 1", e); end
    n_cmp++; if (cnt !== 4'd7)        begin n_fail++; $display("FAIL badcode_cnt got %0d want 7", cnt); end
    n_cmp++; if (disp !== 16'h4567)   begin n_fail++; $display("FAIL badcode_disp got %h want 4567", disp); end
  endtask

  task automatic test_backspace();
    int e;
    do_reset();
    press(4'd4, e); press(4'd5, e);
    backspace(e);
    n_cmp++; if (cnt !== 4'd1)        begin n_fail++; $display("FAIL bs1_cnt got %0d want 1", cnt); end
    n_cmp++; if (disp !== 16'h0004)   begin n_fail++; $display("FAIL bs1_disp got %h want 0004", disp); end
    backspace(e);
    n_cmp++; if (cnt !== 4'd0)        begin n_fail++; $display("FAIL bs2_cnt got %0d want 0", cnt); end
    backspace(e);
    n_cmp++; if (e !== 1)             begin n_fail++; $display("FAIL bs_empty_err got %0d want 1", e); end
    n_cmp++; if (disp !== 16'h0000)   begin n_fail++; $display("FAIL bs_empty_disp got %h want 0000", disp); end
    n_cmp++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL bs_empty_flag got %b want 1", empty); end
  endtask

  task automatic test_handshake();
    int e;
    do_reset();
    press(4'd7, e); press(4'd8, e);
    submit = 1'b1;
    step();
    submit = 1'b0;
    n_cmp++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL sub_valid got %b want 1", out_valid); end
    step(); step();
    n_cmp++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL hold_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0000_0078) begin n_fail++; $display("FAIL hold_data got %h want 00000078", out_data); end
    n_cmp++; if (out_len !== 4'd2)    begin n_fail++; $display("FAIL hold_len got %0d want 2", out_len); end
    press(4'd3, e);
    n_cmp++; if (e !== 1)             begin n_fail++; $display("FAIL hold_press_err got %0d want 1", e); end
    n_cmp++; if (cnt !== 4'd2)        begin n_fail++; $display("FAIL hold_press_cnt got %0d want 2", cnt); end
    n_cmp++; if (out_data !== 32'h0000_0078) begin n_fail++; $display("FAIL hold_press_data got %h want 00000078", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL xfer_valid got %b want 0", out_valid); end
    n_cmp++; if (cnt !== 4'd0)        begin n_fail++; $display("FAIL xfer_cnt got %0d want 0", cnt); end
    n_cmp++; if (disp_blank !== 4'hF) begin n_fail++; $display("FAIL xfer_blank got %b want 1111", disp_blank); end
    // Submitting an empty buffer is rejected and stays in editing.
    submit = 1'b1;
    step();
    submit = 1'b0;
    n_cmp++; if (err !== 1'b1)        begin n_fail++; $display("FAIL empty_submit_err got %b want 1", err); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL empty_submit_valid got %b want 0", out_valid); end
    step();
  endtask

  task automatic test_priority_and_hold();
    int e;
    do_reset();
    press(4'd1, e); press(4'd2, e);
    num = 4'd5; num_pressed = 1'b1; clear = 1'b1;
    step();
    n_cmp++; if (cnt !== 4'd1)        begin n_fail++; $display("FAIL prio_cnt got %0d want 1", cnt); end
    n_cmp++; if (disp !== 16'h0001)   begin n_fail++; $display("FAIL prio_disp got %h want 0001", disp); end
    n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL prio_err got %b want 0", err); end
    num_pressed = 1'b0; clear = 1'b0;
    step();
    num = 4'd6; num_pressed = 1'b1;
    for (int i = 0; i < 10; i++) step();
    num_pressed = 1'b0;
    step();
    n_cmp++; if (cnt !== 4'd2)        begin n_fail++; $display("FAIL held_key_cnt got %0d want 2", cnt); end
    n_cmp++; if (disp !== 16'h0016)   begin n_fail++; $display("FAIL held_key_disp got %h want 0016", disp); end
  endtask

  task automatic test_reset_in_hold();
    int e;
    do_reset();
    press(4'd3, e);
    submit = 1'b1;
    step();
    submit = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL rh_pre_valid got %b want 1", out_valid); end
    num = 4'd4; num_pressed = 1'b1; reset = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rh_valid got %b want 0", out_valid); end
    n_cmp++; if (cnt !== 4'd0)        begin n_fail++; $display("FAIL rh_cnt got %0d want 0", cnt); end
    n_cmp++; if (out_data !== 32'h0)  begin n_fail++; $display("FAIL rh_data got %h want 0", out_data); end
    n_cmp++; if (out_len !== 4'd0)    begin n_fail++; $display("FAIL rh_len got %0d want 0", out_len); end
    n_cmp++; if (disp_blank !== 4'hF) begin n_fail++; $display("FAIL rh_blank got %b want 1111", disp_blank); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rh_flags got e=%b f=%b want e=1 f=0", empty, full); end
    reset = 1'b1;
    step(); step(); step();
    n_cmp++; if (cnt !== 4'd0)        begin n_fail++; $display("FAIL rh_held_cnt got %0d want 0", cnt); end
    num_pressed = 1'b0;
    step();
    num_pressed = 1'b1;
    step();
    num_pressed = 1'b0;
    n_cmp++; if (cnt !== 4'd1)        begin n_fail++; $display("FAIL rh_repress_cnt got %0d want 1", cnt); end
    n_cmp++; if (disp !== 16'h0004)   begin n_fail++; $display("FAIL rh_repress_disp got %h want 0004", disp); end
    step();
  endtask

  initial begin
    reset = 1'b0; num = '0; num_pressed = 0; clear = 0; submit = 0; out_ready = 0;
    test_reset();
    test_push();
    test_full_and_reject();
    test_backspace();
    test_handshake();
    test_priority_and_hold();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
